// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: SGTL5000 PCM Format A frame tracker, lock detector and per-frame tx/rx exchange.
// Define I2S_FRAME_HOLD_ON_UNDERRUN_EN to repeat the last tx frame on underrun instead of sending zeros.
//
// state   | meaning
// NOSIG   | no recent frame edge, no reference period held
// ACQUIRE | counting consecutive in-tolerance frame periods
// LOCKED  | frame timing stable, one tx load / rx capture per period
module i2s_frame_ctrl #(
    parameter int unsigned BITS          = 64,
    parameter int unsigned TIMEOUT       = 4096,
    parameter int unsigned LOCK_FRAMES   = 4,
    parameter int unsigned PERIOD_TOL    = 2,
    parameter int unsigned CAPTURE_DELAY = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lrclk,
    input  logic [BITS-1:0] frame_i,
    output logic [BITS-1:0] frame_o,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            locked,
    output logic [7:0]      underrun_cnt,
    output logic [7:0]      overrun_cnt,
    output logic [15:0]     period
);

    typedef enum logic [1:0] {
        NOSIG   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_lrclk_d;
    logic [15:0]     r_pcnt;
    logic [15:0]     r_ref;
    logic            r_has_ref;
    logic [7:0]      r_good;
    logic [15:0]     r_period;
    logic            r_locked;
    logic [15:0]     r_dly;
    logic            r_arm;
    logic            r_cap;
    logic [BITS-1:0] r_frame_o;
    logic [BITS-1:0] r_rx_data;
    logic            r_rx_valid;
    logic [7:0]      r_und;
    logic [7:0]      r_ovr;

    state_t          w_state_next;
    logic            w_edge;
    logic [15:0]     w_meas;
    logic [15:0]     w_diff;
    logic            w_in_tol;
    logic            w_timeout;
    logic [7:0]      w_good_inc;
    logic [7:0]      w_good_next;
    logic            w_has_ref_next;
    logic            w_leave;

    always_comb begin
        w_edge         = lrclk & ~r_lrclk_d;
        w_meas         = (r_pcnt == 16'hFFFF) ? 16'hFFFF : r_pcnt + 16'd1;
        w_diff         = (w_meas >= r_ref) ? (w_meas - r_ref) : (r_ref - w_meas);
        w_in_tol       = r_has_ref && ({16'd0, w_diff} <= PERIOD_TOL);
        // an edge in the same cycle as the timeout wins
        w_timeout      = !w_edge && (({16'd0, r_pcnt} + 32'd1) >= TIMEOUT);
        w_good_inc     = r_good + 8'd1;
        w_state_next   = r_state;
        w_good_next    = r_good;
        w_has_ref_next = r_has_ref;
        if (w_edge) begin
            w_has_ref_next = 1'b1;
            case (r_state)
                NOSIG: begin
                    w_state_next   = ACQUIRE;
                    w_good_next    = 8'd0;
                    w_has_ref_next = 1'b0;
                end
                ACQUIRE: begin
                    w_good_next = w_in_tol ? w_good_inc : 8'd0;
                    if (w_in_tol && (w_good_inc == 8'(LOCK_FRAMES))) begin
                        w_state_next = LOCKED;
                    end
                end
                default: begin
                    if (!w_in_tol) begin
                        w_state_next = ACQUIRE;
                        w_good_next  = 8'd0;
                    end
                end
            endcase
        end else if (w_timeout) begin
            w_state_next   = NOSIG;
            w_good_next    = 8'd0;
            w_has_ref_next = 1'b0;
        end
        w_leave = (r_state == LOCKED) && (w_state_next != LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= NOSIG;
            r_lrclk_d  <= 1'b0;
            r_pcnt     <= 16'd0;
            r_ref      <= 16'd0;
            r_has_ref  <= 1'b0;
            r_good     <= 8'd0;
            r_period   <= 16'd0;
            r_locked   <= 1'b0;
            r_dly      <= 16'd0;
            r_arm      <= 1'b0;
            r_cap      <= 1'b0;
            r_frame_o  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_und      <= 8'd0;
            r_ovr      <= 8'd0;
        end else begin
            r_lrclk_d <= lrclk;
            if (w_edge) begin
                r_pcnt   <= 16'd0;
                r_period <= w_meas;
                r_ref    <= w_meas;
            end else if (r_pcnt != 16'hFFFF) begin
                r_pcnt <= r_pcnt + 16'd1;
            end
            r_state   <= w_state_next;
            r_good    <= w_good_next;
            r_has_ref <= w_has_ref_next;
            r_locked  <= (w_state_next == LOCKED);

            // capture-point down-counter; a fresh edge restarts it, leaving LOCKED cancels it
            r_cap <= 1'b0;
            if (w_edge) begin
                if (w_state_next != LOCKED) begin
                    r_arm <= 1'b0;
                end else if (CAPTURE_DELAY <= 1) begin
                    r_cap <= 1'b1;
                    r_arm <= 1'b0;
                end else begin
                    r_dly <= 16'(CAPTURE_DELAY - 1);
                    r_arm <= 1'b1;
                end
            end else if (w_leave) begin
                r_arm <= 1'b0;
            end else if (r_arm) begin
                if (r_dly == 16'd1) begin
                    r_cap <= 1'b1;
                    r_arm <= 1'b0;
                end else begin
                    r_dly <= r_dly - 16'd1;
                end
            end

            if (w_leave) begin
                r_frame_o  <= '0;
                r_rx_valid <= 1'b0;
            end else if (r_cap) begin
                if (tx_valid) begin
                    r_frame_o <= tx_data;
                end else begin
`ifdef I2S_FRAME_HOLD_ON_UNDERRUN_EN
                    r_frame_o <= r_frame_o;
`else
                    r_frame_o <= '0;
`endif
                end
                r_rx_data  <= frame_i;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (r_cap && !tx_valid && (r_und != 8'hFF)) begin
                r_und <= r_und + 8'd1;
            end
            if (r_cap && r_rx_valid && !rx_ready && (r_ovr != 8'hFF)) begin
                r_ovr <= r_ovr + 8'd1;
            end
        end
    end

    assign frame_o      = r_frame_o;
    assign tx_ready     = r_cap;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign locked       = r_locked;
    assign underrun_cnt = r_und;
    assign overrun_cnt  = r_ovr;
    assign period       = r_period;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Testbench for i2s_frame_ctrl: per-frame vector table plus directed timeout, relock, re-acquire,
// reset and counter-saturation sequences.
module tb_i2s_frame_ctrl;

`ifdef I2S_FRAME_HOLD_ON_UNDERRUN_EN
    localparam logic [63:0] UF = 64'h0123456789ABCDEF;
`else
    localparam logic [63:0] UF = 64'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lrclk = 1'b0;
    logic [63:0] frame_i = '0;
    logic [63:0] frame_o;
    logic [63:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        locked;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overrun_cnt;
    logic [15:0] period;

    i2s_frame_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lrclk        (lrclk),
        .frame_i      (frame_i),
        .frame_o      (frame_o),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .locked       (locked),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt),
        .period       (period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          per;
        logic        txv;
        logic [63:0] txd;
        logic [63:0] fi;
        logic        rr;
        logic        lk0;
        logic        lk;
        logic [63:0] fo;
        logic        rv;
        logic [63:0] rd;
        logic [7:0]  und;
        logic [7:0]  ovr;
        int          ntx;
    } vec_t;

    vec_t tbl [11];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_txr;
    int   txr_off;
    logic lk0;
    logic lk0_hist [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one lrclk pulse followed by per-1 idle cycles; tx_ready occurrences are counted
    task automatic run_frame(input int per);
        n_txr   = 0;
        txr_off = -1;
        lrclk   = 1'b1;
        tick();
        lrclk   = 1'b0;
        lk0     = locked;
        if (tx_ready) begin
            n_txr++;
            txr_off = 0;
        end
        for (int k = 1; k < per; k++) begin
            tick();
            if (tx_ready) begin
                n_txr++;
                txr_off = k;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            tbl[i] = '{512, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 1'b1,
                       1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 8'd0, 8'd0, 0};
        end
        tbl[5]  = '{512, 1'b1, 64'hDEADBEEF00C0FFEE, 64'hA5A5A5A5A5A5A5A5, 1'b1,
                    1'b1, 1'b1, 64'hDEADBEEF00C0FFEE, 1'b0, 64'hA5A5A5A5A5A5A5A5, 8'd0, 8'd0, 1};
        tbl[6]  = '{512, 1'b1, 64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0,
                    1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b1, 64'h1111111111111111, 8'd0, 8'd0, 1};
        tbl[7]  = '{512, 1'b0, 64'h0, 64'h2222222222222222, 1'b0,
                    1'b1, 1'b1, UF, 1'b1, 64'h2222222222222222, 8'd1, 8'd1, 1};
        tbl[8]  = '{512, 1'b0, 64'h0, 64'h3333333333333333, 1'b1,
                    1'b1, 1'b1, UF, 1'b0, 64'h3333333333333333, 8'd2, 8'd1, 1};
        tbl[9]  = '{512, 1'b0, 64'h0, 64'h4444444444444444, 1'b1,
                    1'b1, 1'b1, UF, 1'b0, 64'h4444444444444444, 8'd3, 8'd1, 1};
        tbl[10] = '{512, 1'b1, 64'hFEDCBA9876543210, 64'h5555555555555555, 1'b0,
                    1'b1, 1'b1, 64'hFEDCBA9876543210, 1'b1, 64'h5555555555555555, 8'd3, 8'd1, 1};

        // reset state
        tick();
        tick();
        chk("reset locked", 64'(locked), 64'd0);
        chk("reset frame_o", frame_o, 64'd0);
        chk("reset tx_ready", 64'(tx_ready), 64'd0);
        chk("reset rx_valid", 64'(rx_valid), 64'd0);
        chk("reset period", 64'(period), 64'd0);
        rst_n = 1'b1;
        tick();

        // acquisition, lock, tx load, underrun, overrun
        for (int i = 0; i < 11; i++) begin
            tx_valid = tbl[i].txv;
            tx_data  = tbl[i].txd;
            frame_i  = tbl[i].fi;
            rx_ready = tbl[i].rr;
            run_frame(tbl[i].per);
            chk($sformatf("row%0d locked_at_edge+1", i), 64'(lk0), 64'(tbl[i].lk0));
            chk($sformatf("row%0d locked", i), 64'(locked), 64'(tbl[i].lk));
            chk($sformatf("row%0d frame_o", i), frame_o, tbl[i].fo);
            chk($sformatf("row%0d rx_valid", i), 64'(rx_valid), 64'(tbl[i].rv));
            chk($sformatf("row%0d rx_data", i), rx_data, tbl[i].rd);
            chk($sformatf("row%0d underrun_cnt", i), 64'(underrun_cnt), 64'(tbl[i].und));
            chk($sformatf("row%0d overrun_cnt", i), 64'(overrun_cnt), 64'(tbl[i].ovr));
            chk($sformatf("row%0d tx_ready_count", i), 64'(n_txr), 64'(tbl[i].ntx));
            if (tbl[i].ntx == 1) begin
                chk($sformatf("row%0d tx_ready_offset", i), 64'(txr_off), 64'd7);
            end
        end
        chk("locked period", 64'(period), 64'd512);

        // rx_ready drains a pending frame on the following cycle
        rx_ready = 1'b1;
        tick();
        chk("rx drain", 64'(rx_valid), 64'd0);

        // one more locked frame (gap 513, within tolerance) leaving rx pending
        rx_ready = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 64'h0F0F0F0F0F0F0F0F;
        frame_i  = 64'h6666666666666666;
        run_frame(511);
        chk("period 513", 64'(period), 64'd513);
        chk("pending rx_valid", 64'(rx_valid), 64'd1);
        chk("pending frame_o", frame_o, 64'h0F0F0F0F0F0F0F0F);

        // lrclk stops: lock drops exactly 4096 cycles after the last edge
        for (int k = 0; k < 3585; k++) tick();
        chk("timeout-1 locked", 64'(locked), 64'd1);
        tick();
        chk("timeout locked", 64'(locked), 64'd0);
        chk("timeout frame_o", frame_o, 64'd0);
        chk("timeout rx_valid", 64'(rx_valid), 64'd0);
        chk("timeout underrun kept", 64'(underrun_cnt), 64'd3);
        chk("timeout overrun kept", 64'(overrun_cnt), 64'd1);

        // pulses resume: relock one cycle after the sixth edge
        tx_data  = 64'hDEADBEEF00C0FFEE;
        frame_i  = 64'h7777777777777777;
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_frame(512);
            lk0_hist[i] = lk0;
        end
        chk("relock edge5", 64'(lk0_hist[4]), 64'd0);
        chk("relock edge6", 64'(lk0_hist[5]), 64'd1);
        chk("relock frame_o", frame_o, 64'hDEADBEEF00C0FFEE);

        // a 600-cycle period drops lock on the next cycle
        for (int k = 0; k < 88; k++) tick();
        lrclk = 1'b1;
        tick();
        lrclk = 1'b0;
        chk("bad period locked", 64'(locked), 64'd0);
        chk("bad period value", 64'(period), 64'd600);
        chk("bad period frame_o", frame_o, 64'd0);

        // async reset mid-frame clears outputs immediately
        for (int k = 0; k < 50; k++) tick();
        chk("pre-reset underrun", 64'(underrun_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("async reset underrun", 64'(underrun_cnt), 64'd0);
        chk("async reset overrun", 64'(overrun_cnt), 64'd0);
        chk("async reset period", 64'(period), 64'd0);
        chk("async reset rx_data", rx_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // short frames with no tx data and no rx consumer: both counters saturate
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        for (int i = 0; i < 264; i++) run_frame(20);
        chk("sat locked", 64'(locked), 64'd1);
        chk("sat underrun", 64'(underrun_cnt), 64'd255);
        chk("sat overrun", 64'(overrun_cnt), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_frame_ctrl.md
Name: i2s_frame_ctrl

Overview:
Frame-level controller for the SGTL5000 PCM Format A serial port. It tracks the one-cycle I2S_LRCLK frame pulse, qualifies the frame period, and declares lock. Once locked, it exchanges one BITS-wide frame per period:
- It loads the next transmit frame into the serial port's parallel output.
- It captures the received frame.
- It presents both to the SID core through valid/ready handshakes, with underrun and overrun accounting.

Parameters:
BITS, 64, frame width (both directions)
TIMEOUT, 4096, clk cycles without a frame edge before declaring signal loss (max 65535)
LOCK_FRAMES, 4, consecutive in-tolerance periods required to lock
PERIOD_TOL, 2, allowed |period - previous period| in clk cycles
CAPTURE_DELAY, 8, clk cycles after frame edge at which rx capture and tx load occur

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lrclk  in  1  I2S_LRCLK, already synchronised to clk
frame_i  in  BITS  received frame from serial port parallel output
frame_o  out  BITS  transmit frame to serial port parallel input
tx_data  in  BITS  next frame from SID core
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle transfer strobe
rx_data  out  BITS  captured frame
rx_valid  out  1  rx_data pending
rx_ready  in  1  consumer accepts rx_data
locked  out  1  frame timing locked
underrun_cnt  out  8  saturating tx underrun count
overrun_cnt  out  8  saturating rx overrun count
period  out  16  last measured frame period in clk cycles

Behaviour:
- Reset (async assert, sync release): all outputs are 0, state NOSIG, internal counters 0.
- Frame edge is a rising edge of lrclk (previous sample 0, current sample 1). Period counter: 16 bits, cleared on each edge, saturates at 0xFFFF.
- FSM NOSIG:
  - Edge → ACQUIRE.
  - No reference period is held yet; good = 0.
- FSM ACQUIRE:
  - Each edge latches period.
  - If a reference exists and |new − ref| ≤ PERIOD_TOL, good++; otherwise good = 0.
  - ref ← new on every edge.
  - good == LOCK_FRAMES → LOCKED.
- FSM LOCKED:
  - An edge with an out-of-tolerance period → ACQUIRE with good = 0. The new period becomes ref.
- Timeout: in any state, period counter reaching TIMEOUT with no edge → NOSIG. If an edge and the timeout fall in the same cycle, the edge wins.
- locked = (state == LOCKED), registered; it changes in the cycle after the transition.
- Capture point, LOCKED only: CAPTURE_DELAY cycles after an edge. A new edge before that point cancels the pending capture and restarts the delay.
- At the capture point:
  - rx: rx_data ← frame_i and rx_valid ← 1. If rx_valid was already 1 and rx_ready is 0 in that cycle, overrun_cnt++ (saturate at 255) and the old data is overwritten. If rx_ready is 1 in the same cycle, there is no overrun.
  - tx: tx_ready is 1 for exactly this cycle.
    - If tx_valid: frame_o ← tx_data.
    - Else: underrun, underrun_cnt++ (saturate at 255), and frame_o ← 0.
- rx handshake: rx_valid clears on the cycle after rx_valid & rx_ready, unless a new capture happens in that cycle.
- tx_ready is never asserted outside the capture point.
- frame_o is stable between capture points. The serial port samples it at the next frame pulse, one full period later.
- Leaving LOCKED (either to ACQUIRE or to NOSIG), in the next cycle:
  - frame_o ← 0
  - rx_valid ← 0
  - any pending capture is cancelled
  - counters are retained
- Counters clear only on reset.

Optional Feature:
Macro I2S_FRAME_HOLD_ON_UNDERRUN_EN.
- Defined: on underrun, frame_o keeps its previous value (repeat the last sample). underrun_cnt still increments.
- Undefined: frame_o ← 0 on underrun.
- Leaving LOCKED forces frame_o to 0 in both cases.

Test Plan:
1. Reset, then lrclk pulses every 512 clk → locked = 1 one cycle after the 6th edge, period = 512. No tx_ready before lock.
2. Locked, tx_valid = 1, tx_data = 0xDEADBEEF00C0FFEE → tx_ready pulses once at edge + 8, frame_o = 0xDEADBEEF00C0FFEE at edge + 9.
3. Locked, tx_valid = 0 for 3 frames → underrun_cnt = 3, frame_o = 0 (with HOLD_EN: frame_o holds the prior value).
4. Locked, rx_ready = 0, frame_i = 0x1111… then 0x2222… → overrun_cnt = 1, rx_data = 0x2222…, rx_valid = 1. Then rx_ready = 1 → rx_valid = 0 next cycle.
5. Locked, lrclk stops → locked = 0 after 4096 cycles + 1, frame_o = 0, rx_valid = 0. Pulses resume at 512 → relock after 6 edges.
6. Locked at 512, one period of 600 → locked = 0 next cycle, state ACQUIRE. rst_n asserted mid-frame → all outputs 0 immediately.
